// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N systolic MAC grid: clears the accumulators, drives the
// skewed operand feed (per-lane enables and indices) and hands result rows out.

module systolic_ctrl_lane #(
  parameter int KW   = 5,
  parameter int TW   = 6,
  parameter int LANE = 0
) (
  input  logic          feed_i,
  input  logic [TW-1:0] t_i,
  input  logic [KW-1:0] kq_i,
  output logic          en_o,
  output logic [KW-1:0] idx_o
);
  localparam logic [TW:0] LO = (TW+1)'(LANE);

  logic [TW:0] off;

  // t < LANE wraps to a huge offset, so one compare covers both window edges.
  assign off   = {1'b0, t_i} - LO;
  assign en_o  = feed_i && (off < (TW+1)'(kq_i));
  assign idx_o = en_o ? off[KW-1:0] : '0;
endmodule

module systolic_ctrl #(
  parameter  int N    = 4,
  parameter  int KMAX = 16,
  parameter  int KW   = 5,
  parameter  int TW   = 6,
  localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            arr_clr,
  output logic [TW-1:0]   feed_t,
  output logic [N-1:0]    row_en,
  output logic [N-1:0]    col_en,
  output logic [N*KW-1:0] a_idx,
  output logic [N*KW-1:0] b_idx,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RW-1:0]   res_row,
  output logic            done
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [KW-1:0] KMAX_K = KW'(KMAX);
  localparam logic [TW-1:0] SKEW   = TW'(2*N-3);
  localparam logic [RW-1:0] LAST_R = RW'(N-1);

  state_t        state_q, state_d;
  logic [KW-1:0] kq_q, kq_d;
  logic [TW-1:0] t_q, t_d;
  logic [RW-1:0] r_q, r_d;
  logic          clr_q, clr_d;

  logic [TW-1:0] t_last;
  logic          feed_act;
  logic [N-1:0]  lane_en;
  logic [N*KW-1:0] lane_idx;

  assign t_last   = TW'(kq_q) + SKEW;
  assign feed_act = (state_q == S_FEED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kq_q    <= '0;
      t_q     <= '0;
      r_q     <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kq_q    <= kq_d;
      t_q     <= t_d;
      r_q     <= r_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kq_d    = kq_q;
    t_d     = t_q;
    r_d     = r_q;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Out-of-range K is clamped so the step counter can never wrap.
          kq_d    = (k_len > KMAX_K) ? KMAX_K : k_len;
          clr_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        r_d     = '0;
        state_d = (kq_q == '0) ? S_READ : S_FEED;
      end
      S_FEED: begin
        if (t_q == t_last) begin
          t_d     = '0;
          r_d     = '0;
          state_d = S_READ;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_READ: begin
        if (res_ready) begin
          if (r_q == LAST_R) begin
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row and column lanes share the same skew rule, so one lane array serves both.
  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_ctrl_lane #(.KW(KW), .TW(TW), .LANE(i)) u_lane (
      .feed_i (feed_act),
      .t_i    (t_q),
      .kq_i   (kq_q),
      .en_o   (lane_en[i]),
      .idx_o  (lane_idx[i*KW +: KW])
    );
  end

  assign busy      = (state_q != S_IDLE);
  assign arr_clr   = clr_q;
  assign feed_t    = feed_act ? t_q : '0;
  assign row_en    = lane_en;
  assign col_en    = lane_en;
  assign a_idx     = lane_idx;
  assign b_idx     = lane_idx;
  assign res_valid = (state_q == S_READ);
  assign res_row   = (state_q == S_READ) ? r_q : '0;
  assign done      = (state_q == S_DONE);
endmodule
